// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   - FSM state encoding (IDLE/FETCH/DONE)
//   - 16-bit word type
//   - default parameter values for reset PC, PC increment and fetch timeout
package instr_fetch_unit_pkg;

    localparam int WORD_W = 16;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t DEF_RESET_PC = 16'h0000;
    localparam int    DEF_PC_INC   = 2;
    localparam int    DEF_TIMEOUT  = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_DONE  = 2'b10
    } ifu_state_t;

endpackage

// File: rtl/instr_fetch_unit_pc_reg.sv
// pc_reg: program counter register.
//   clk, rst_n : clock, asynchronous active-low reset (loads RESET_PC)
//   load       : load pc from pc_in (takes priority over inc)
//   inc        : advance pc by PC_INC, wrapping modulo 2^16
//   pc_in      : value to load
//   pc         : current program counter
module pc_reg
    import instr_fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = DEF_RESET_PC,
    parameter int    PC_INC   = DEF_PC_INC
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  inc,
    input  word_t pc_in,
    output word_t pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= pc_in;
        end else if (inc) begin
            pc <= pc + word_t'(PC_INC);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches one 16-bit instruction per FetchGo request.
//   CLK, Reset_n      : clock, asynchronous active-low reset
//   FetchGo           : request next instruction (honoured only in IDLE)
//   PCWrite, PCIn     : load PC (jump/branch); aborts an in-flight fetch
//   MemReady, MemRData: memory read data valid / data
//   MemReq, MemAddr   : memory read request / address (address = PC)
//   Instruction       : last captured instruction, held until next capture
//   IREnable          : one-cycle pulse when Instruction is new
//   PC                : address of next instruction to fetch
//   Busy              : high in FETCH and DONE
//   FetchFault        : sticky memory-timeout flag, cleared by PCWrite
//   dbg_state         : current FSM state encoding
//
// Handshake: while in FETCH, MemReq stays high and MemAddr stays stable
// until a cycle in which MemReady is sampled high (data accepted that
// cycle), the wait counter times out, or PCWrite aborts the fetch.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = DEF_RESET_PC,
    parameter int    PC_INC   = DEF_PC_INC,
    parameter int    TIMEOUT  = DEF_TIMEOUT
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        FetchGo,
    input  logic        PCWrite,
    input  logic [15:0] PCIn,
    input  logic        MemReady,
    input  logic [15:0] MemRData,
    output logic        MemReq,
    output logic [15:0] MemAddr,
    output logic [15:0] Instruction,
    output logic        IREnable,
    output logic [15:0] PC,
    output logic        Busy,
    output logic        FetchFault,
    output logic [1:0]  dbg_state
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    ifu_state_t       state, next_state;
    logic [CNT_W-1:0] wait_cnt;
    logic             pc_inc;
    logic             capture;
    logic             fault_set;

    pc_reg #(
        .RESET_PC (RESET_PC),
        .PC_INC   (PC_INC)
    ) u_pc_reg (
        .clk   (CLK),
        .rst_n (Reset_n),
        .load  (PCWrite),
        .inc   (pc_inc),
        .pc_in (PCIn),
        .pc    (PC)
    );

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // PCWrite has top priority in FETCH: it discards any same-cycle data.
    // The timeout fires on the TIMEOUT-th consecutive FETCH cycle without
    // MemReady.
    always_comb begin
        next_state = state;
        pc_inc     = 1'b0;
        capture    = 1'b0;
        fault_set  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (FetchGo) next_state = ST_FETCH;
            end
            ST_FETCH: begin
                if (PCWrite) begin
                    next_state = ST_IDLE;
                end else if (MemReady) begin
                    next_state = ST_DONE;
                    pc_inc     = 1'b1;
                    capture    = 1'b1;
                end else if (wait_cnt == CNT_LAST) begin
                    next_state = ST_IDLE;
                    fault_set  = 1'b1;
                end
            end
            ST_DONE: begin
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Counts only while staying in FETCH; any exit clears it.
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            wait_cnt <= '0;
        end else if ((state == ST_FETCH) && (next_state == ST_FETCH)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            Instruction <= 16'h0000;
        end else if (capture) begin
            Instruction <= MemRData;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            FetchFault <= 1'b0;
        end else if (PCWrite) begin
            FetchFault <= 1'b0;
        end else if (fault_set) begin
            FetchFault <= 1'b1;
        end
    end

    assign MemReq    = (state == ST_FETCH);
    assign IREnable  = (state == ST_DONE);
    assign Busy      = (state != ST_IDLE);
    assign MemAddr   = PC;
    assign dbg_state = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic        CLK;
    logic        Reset_n;
    logic        FetchGo;
    logic        PCWrite;
    logic [15:0] PCIn;
    logic        MemReady;
    logic [15:0] MemRData;
    logic        MemReq;
    logic [15:0] MemAddr;
    logic [15:0] Instruction;
    logic        IREnable;
    logic [15:0] PC;
    logic        Busy;
    logic        FetchFault;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    // Expected IREnable events: {instruction, PC during the pulse}
    logic [31:0] exp_q[$];
    logic [31:0] exp_item;

    instr_fetch_unit dut (
        .CLK         (CLK),
        .Reset_n     (Reset_n),
        .FetchGo     (FetchGo),
        .PCWrite     (PCWrite),
        .PCIn        (PCIn),
        .MemReady    (MemReady),
        .MemRData    (MemRData),
        .MemReq      (MemReq),
        .MemAddr     (MemAddr),
        .Instruction (Instruction),
        .IREnable    (IREnable),
        .PC          (PC),
        .Busy        (Busy),
        .FetchFault  (FetchFault),
        .dbg_state   (dbg_state)
    );

    // Clock
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every IREnable pulse must match the head of the expected queue.
    always @(negedge CLK) begin
        if (Reset_n && IREnable) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_irenable: pulse with instr=%h pc=%h, expected no pulse",
                         Instruction, PC);
            end else begin
                exp_item = exp_q.pop_front();
                check16("ir_instr", Instruction, exp_item[31:16]);
                check16("ir_pc", PC, exp_item[15:0]);
            end
        end
    end

    // Full fetch: FetchGo one cycle, MemReady after 'waits' FETCH cycles.
    task automatic do_fetch(input logic [15:0] data, input logic [15:0] exp_addr,
                            input int waits, input logic [15:0] exp_pc);
        FetchGo = 1'b1;
        step();
        FetchGo = 1'b0;
        check16("fetch_memreq", {15'b0, MemReq}, 16'h0001);
        check16("fetch_addr", MemAddr, exp_addr);
        repeat (waits) step();
        check16("fetch_addr_held", MemAddr, exp_addr);
        MemReady = 1'b1;
        MemRData = data;
        exp_q.push_back({data, exp_pc});
        step();
        MemReady = 1'b0;
        MemRData = 16'h0000;
        step();
        check16("fetch_idle_busy", {15'b0, Busy}, 16'h0000);
    endtask

    initial begin
        // Reset
        Reset_n  = 1'b0;
        FetchGo  = 1'b0;
        PCWrite  = 1'b0;
        PCIn     = 16'h0000;
        MemReady = 1'b0;
        MemRData = 16'h0000;
        repeat (2) step();
        check16("rst_pc", PC, 16'h0000);
        check16("rst_memaddr", MemAddr, 16'h0000);
        check16("rst_instr", Instruction, 16'h0000);
        check16("rst_flags", {11'b0, MemReq, IREnable, Busy, FetchFault, 1'b0}, 16'h0000);
        check16("rst_state", {14'b0, dbg_state}, 16'h0000);
        Reset_n = 1'b1;
        step();

        // Basic fetch, MemReady two cycles after FetchGo
        do_fetch(16'hA5C3, 16'h0000, 1, 16'h0002);
        check16("basic_pc", PC, 16'h0002);
        check16("basic_instr_held", Instruction, 16'hA5C3);

        // Zero-wait fetch
        do_fetch(16'h1357, 16'h0002, 0, 16'h0004);

        // PC wrap from 16'hFFFE
        PCWrite = 1'b1;
        PCIn    = 16'hFFFE;
        step();
        PCWrite = 1'b0;
        check16("wr_pc_fffe", PC, 16'hFFFE);
        do_fetch(16'hBEEF, 16'hFFFE, 2, 16'h0000);
        check16("wrap_pc", PC, 16'h0000);

        // PCWrite with FetchGo in IDLE: fetch uses new PC
        PCWrite = 1'b1;
        PCIn    = 16'h0100;
        FetchGo = 1'b1;
        step();
        PCWrite = 1'b0;
        FetchGo = 1'b0;
        check16("wrgo_addr", MemAddr, 16'h0100);
        check16("wrgo_memreq", {15'b0, MemReq}, 16'h0001);
        MemReady = 1'b1;
        MemRData = 16'h2468;
        exp_q.push_back({16'h2468, 16'h0102});
        step();
        MemReady = 1'b0;
        // In DONE: PCWrite overrides increment, FetchGo ignored
        PCWrite = 1'b1;
        PCIn    = 16'h0200;
        FetchGo = 1'b1;
        step();
        PCWrite = 1'b0;
        FetchGo = 1'b0;
        check16("done_wr_pc", PC, 16'h0200);
        check16("done_go_ignored", {15'b0, Busy}, 16'h0000);

        // FetchGo held through FETCH is not queued
        FetchGo = 1'b1;
        step();
        MemReady = 1'b1;
        MemRData = 16'h4321;
        exp_q.push_back({16'h4321, 16'h0202});
        step();
        FetchGo  = 1'b0;
        MemReady = 1'b0;
        step();
        check16("fetch_go_ignored", {15'b0, Busy}, 16'h0000);

        // Timeout after 15 FETCH cycles without MemReady
        FetchGo = 1'b1;
        step();
        FetchGo = 1'b0;
        repeat (14) step();
        check16("to_still_fetch", {15'b0, MemReq}, 16'h0001);
        check16("to_no_fault_yet", {15'b0, FetchFault}, 16'h0000);
        step();
        check16("to_memreq_low", {15'b0, MemReq}, 16'h0000);
        check16("to_fault", {15'b0, FetchFault}, 16'h0001);
        check16("to_pc_same", PC, 16'h0202);
        check16("to_instr_same", Instruction, 16'h4321);
        // Fetch still allowed while faulted; fault stays sticky
        do_fetch(16'h5A5A, 16'h0202, 0, 16'h0204);
        check16("fault_sticky", {15'b0, FetchFault}, 16'h0001);
        PCWrite = 1'b1;
        PCIn    = 16'h0300;
        step();
        PCWrite = 1'b0;
        check16("fault_cleared", {15'b0, FetchFault}, 16'h0000);
        check16("fault_clr_pc", PC, 16'h0300);

        // PCWrite wins over same-cycle MemReady
        FetchGo = 1'b1;
        step();
        FetchGo  = 1'b0;
        MemReady = 1'b1;
        MemRData = 16'hDEAD;
        PCWrite  = 1'b1;
        PCIn     = 16'h0040;
        step();
        MemReady = 1'b0;
        PCWrite  = 1'b0;
        check16("abort_memreq", {15'b0, MemReq}, 16'h0000);
        check16("abort_state", {14'b0, dbg_state}, 16'h0000);
        check16("abort_pc", PC, 16'h0040);
        check16("abort_instr", Instruction, 16'h5A5A);
        step();
        check16("abort_no_ire", {15'b0, IREnable}, 16'h0000);

        // Asynchronous reset mid-fetch
        FetchGo = 1'b1;
        step();
        FetchGo = 1'b0;
        check16("arst_pre_memreq", {15'b0, MemReq}, 16'h0001);
        #2;
        Reset_n = 1'b0;
        #1;
        check16("arst_memreq", {15'b0, MemReq}, 16'h0000);
        check16("arst_pc", PC, 16'h0000);
        check16("arst_instr", Instruction, 16'h0000);
        check16("arst_busy", {15'b0, Busy}, 16'h0000);
        step();
        Reset_n = 1'b1;
        step();
        MemReady = 1'b1;
        MemRData = 16'hFFFF;
        step();
        MemReady = 1'b0;
        step();
        check16("arst_late_ready_busy", {15'b0, Busy}, 16'h0000);
        check16("arst_late_ready_instr", Instruction, 16'h0000);
        check16("arst_late_ready_pc", PC, 16'h0000);
        do_fetch(16'hC0DE, 16'h0000, 3, 16'h0002);

        step();
        check16("queue_drained", 16'(exp_q.size()), 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, PC value loaded at reset.
REQ-002 Parameter PC_INC, default 2, PC increment per fetched 16-bit instruction (byte addressing).
REQ-003 Parameter TIMEOUT, default 15, max FETCH cycles without MemReady before fault.
REQ-004 CLK  input  1  single clock, all state updates on rising edge.
REQ-005 Reset_n  input  1  asynchronous, active-low reset.
REQ-006 FetchGo  input  1  control unit request for the next instruction.
REQ-007 PCWrite  input  1  load PC from PCIn (jump/branch).
REQ-008 PCIn  input  16  new PC value.
REQ-009 MemReady  input  1  memory read data valid.
REQ-010 MemRData  input  16  memory read data.
REQ-011 MemReq  output  1  memory read request.
REQ-012 MemAddr  output  16  memory read address.
REQ-013 Instruction  output  16  fetched instruction, feeds IR Instruction input.
REQ-014 IREnable  output  1  one-cycle pulse, feeds IR enable input.
REQ-015 PC  output  16  address of next instruction to fetch.
REQ-016 Busy  output  1  high in FETCH and DONE.
REQ-017 FetchFault  output  1  sticky memory-timeout flag.

Function
REQ-018 FSM states IDLE, FETCH, DONE; all outputs registered or decoded from state only.
REQ-019 IDLE: FetchGo=1 -> FETCH next cycle; else stay.
REQ-020 FETCH: MemReq=1, MemAddr=PC, held stable until MemReady sampled 1 or fetch aborted.
REQ-021 FETCH with MemReady=1: Instruction<=MemRData, PC<=PC+PC_INC (mod 2^16, 16'hFFFE+2=16'h0000), wait counter cleared, -> DONE.
REQ-022 DONE: IREnable=1 for exactly one cycle, -> IDLE; Instruction held until next capture.
REQ-023 Latency: FetchGo in cycle 0 -> MemReq in cycle 1; MemReady in cycle k -> IREnable in cycle k+1.
REQ-024 FETCH without MemReady: wait counter +1; counter reaching TIMEOUT -> FetchFault<=1, PC unchanged, Instruction unchanged, no IREnable, -> IDLE.
REQ-025 FetchFault cleared only by reset or PCWrite; FetchGo while FetchFault=1 still starts a fetch.
REQ-026 PCWrite in IDLE: PC<=PCIn; with simultaneous FetchGo, the following FETCH uses PCIn.
REQ-027 PCWrite in FETCH: aborts fetch, PC<=PCIn, MemReq low next cycle, -> IDLE, no IREnable; wins over same-cycle MemReady (data discarded).
REQ-028 PCWrite in DONE: PC<=PCIn (overrides increment), IREnable pulse still issued.
REQ-029 FetchGo in FETCH or DONE ignored (not queued).

Reset
REQ-030 Reset_n=0 asynchronously: state IDLE, PC=RESET_PC, Instruction=16'h0000, wait counter=0, MemReq=0, MemAddr=RESET_PC, IREnable=0, Busy=0, FetchFault=0.
REQ-031 Reset mid-fetch: MemReq drops immediately, pending MemReady after release ignored unless a new FETCH is active.

Structure
REQ-032 Shared package holds state encoding (IDLE=2'b00, FETCH=2'b01, DONE=2'b10), 16-bit word width and default RESET_PC/PC_INC/TIMEOUT constants.
REQ-033 One sub-module pc_reg: 16-bit PC register with load (PCIn) and increment (PC_INC) controls, load priority over increment.

Verification
REQ-034 Reset, FetchGo=1 one cycle, MemReady=1 with MemRData=16'hA5C3 two cycles later -> MemAddr=16'h0000 during FETCH, IREnable pulse with Instruction=16'hA5C3, PC=16'h0002.
REQ-035 PCWrite=1 PCIn=16'hFFFE then FetchGo, MemReady -> MemAddr=16'hFFFE, PC wraps to 16'h0000.
REQ-036 FetchGo, MemReady held low 15 cycles -> FetchFault=1, no IREnable, PC unchanged; then PCWrite -> FetchFault=0.
REQ-037 PCWrite PCIn=16'h0040 in same cycle as MemReady during FETCH -> no IREnable, Instruction unchanged, PC=16'h0040, state IDLE.
REQ-038 Reset_n pulsed low while MemReq=1 -> MemReq=0 asynchronously, PC=RESET_PC, later MemReady pulse produces no IREnable.
